// File: rtl/sync_downcount.sv
// Loadable down counter / interval timer with one-shot and auto-reload modes and a one-cycle tc pulse.
// Outputs register one cycle after the qualifying edge; no backpressure, en simply gates counting.
module sync_downcount #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] rld, rld_nxt;
    logic             tc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            tc    <= 1'b0;
            rld   <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            tc    <= tc_nxt;
            rld   <= rld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        rld_nxt   = rld;
        tc_nxt    = 1'b0;
        if (load) begin
            rld_nxt   = load_val;
            q_nxt     = load_val;
            state_nxt = (load_val != '0) ? RUN : IDLE;
        end else if (en && state == RUN) begin
            if (q > ONE) begin
                q_nxt = q - ONE;
            end else if (q == ONE) begin
                q_nxt  = '0;
                tc_nxt = 1'b1;
                if (!auto_reload) state_nxt = DONE;
            end else begin
                // q==0 in RUN only follows an auto-reload expiry; mode decides reload vs stop
                if (auto_reload) q_nxt = rld;
                else             state_nxt = DONE;
            end
        end
    end

    assign busy = (state == RUN);
    assign zero = (q == '0);

endmodule
